// File: rtl/cfu_cmd_master.sv
// CFU command/response initiator. Requests are queued, then issued to the CFU
// under a credit scheme that reserves a result slot for every in-flight command.
module cfu_cmd_master #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [9:0]               req_function_id,
  input  logic [31:0]              req_inputs_0,
  input  logic [31:0]              req_inputs_1,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [9:0]               cmd_payload_function_id,
  output logic [31:0]              cmd_payload_inputs_0,
  output logic [31:0]              cmd_payload_inputs_1,
  input  logic                     rsp_valid,
  output logic                     rsp_ready,
  input  logic [31:0]              rsp_payload_outputs_0,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     idle,
  output logic                     error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW:0]   CREDIT_MAX = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
  } cmd_t;

  cmd_t          cmd_mem_q [DEPTH];
  cmd_t          cmd_mem_d [DEPTH];
  logic [AW-1:0] cmd_wr_q, cmd_wr_d;
  logic [AW-1:0] cmd_rd_q, cmd_rd_d;
  logic [CW-1:0] cmd_cnt_q, cmd_cnt_d;

  logic [31:0]   res_mem_q [DEPTH];
  logic [31:0]   res_mem_d [DEPTH];
  logic [AW-1:0] res_wr_q, res_wr_d;
  logic [AW-1:0] res_rd_q, res_rd_d;
  logic [CW-1:0] res_cnt_q, res_cnt_d;

  logic [CW-1:0] out_q, out_d;
  logic          err_q, err_d;

  logic [CW:0]   credit_sum;
  logic          credit_ok;
  logic          cmd_push;
  logic          cmd_issue;
  logic          rsp_take;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          res_pop;
  cmd_t          cmd_head;

  // Credit counts results still owed plus results already queued, so a
  // result slot always exists for anything issued.
  assign credit_sum = {1'b0, out_q} + {1'b0, res_cnt_q};
  assign credit_ok  = credit_sum < CREDIT_MAX;

  assign req_ready = !reset && (cmd_cnt_q != FULL_CNT);
  assign cmd_valid = !reset && (cmd_cnt_q != '0) && credit_ok;
  assign rsp_ready = !reset;
  assign res_valid = !reset && (res_cnt_q != '0);

  assign cmd_head                = cmd_mem_q[cmd_rd_q];
  assign cmd_payload_function_id = cmd_head.fid;
  assign cmd_payload_inputs_0    = cmd_head.in0;
  assign cmd_payload_inputs_1    = cmd_head.in1;
  assign res_data                = res_mem_q[res_rd_q];

  assign outstanding = out_q;
  assign idle        = (cmd_cnt_q == '0) && (out_q == '0) && (res_cnt_q == '0);
  assign error       = err_q;

  assign cmd_push  = req_valid && req_ready;
  assign cmd_issue = cmd_valid && cmd_ready;
  assign rsp_take  = rsp_valid && rsp_ready;
  assign rsp_keep  = rsp_take && (out_q != '0);
  assign rsp_drop  = rsp_take && (out_q == '0);
  assign res_pop   = res_valid && res_ready;

  always_comb begin
    cmd_mem_d = cmd_mem_q;
    cmd_wr_d  = cmd_wr_q;
    cmd_rd_d  = cmd_rd_q;
    if (cmd_push) begin
      cmd_mem_d[cmd_wr_q] = {req_function_id, req_inputs_0, req_inputs_1};
      cmd_wr_d            = cmd_wr_q + 1'b1;
    end
    if (cmd_issue) begin
      cmd_rd_d = cmd_rd_q + 1'b1;
    end
    cmd_cnt_d = cmd_cnt_q + CW'(cmd_push) - CW'(cmd_issue);
  end

  always_comb begin
    res_mem_d = res_mem_q;
    res_wr_d  = res_wr_q;
    res_rd_d  = res_rd_q;
    if (rsp_keep) begin
      res_mem_d[res_wr_q] = rsp_payload_outputs_0;
      res_wr_d            = res_wr_q + 1'b1;
    end
    if (res_pop) begin
      res_rd_d = res_rd_q + 1'b1;
    end
    res_cnt_d = res_cnt_q + CW'(rsp_keep) - CW'(res_pop);
  end

  // A response arriving with nothing owed is dropped and latched as an error.
  always_comb begin
    out_d = out_q + CW'(cmd_issue) - CW'(rsp_keep);
    err_d = err_q | rsp_drop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_wr_q  <= '0;
      cmd_rd_q  <= '0;
      cmd_cnt_q <= '0;
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      res_cnt_q <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      cmd_wr_q  <= cmd_wr_d;
      cmd_rd_q  <= cmd_rd_d;
      cmd_cnt_q <= cmd_cnt_d;
      res_wr_q  <= res_wr_d;
      res_rd_q  <= res_rd_d;
      res_cnt_q <= res_cnt_d;
      out_q     <= out_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: pushes are blocked while reset is high.
  always_ff @(posedge clk) begin
    cmd_mem_q <= cmd_mem_d;
    res_mem_q <= res_mem_d;
  end

endmodule

// File: tb/tb_cfu_cmd_master.sv
// Self-checking bench for cfu_cmd_master: behavioural CFU and consumer with an
// occupancy/order reference model, table vectors, and multi-cycle corner cases.
module tb_cfu_cmd_master;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_function_id = '0;
  logic [31:0] req_inputs_0 = '0;
  logic [31:0] req_inputs_1 = '0;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  outstanding;
  logic        idle;
  logic        error;

  always #5 clk = ~clk;

  cfu_cmd_master #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_function_id(req_function_id),
    .req_inputs_0(req_inputs_0), .req_inputs_1(req_inputs_1),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0),
    .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .outstanding(outstanding), .idle(idle), .error(error)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Environment knobs (written by the test, read by the environment)
  bit          cfu_stall = 0, cfu_hold = 0, cfu_rand = 0;
  bit          res_en = 1, res_rand = 0, inject = 0;
  logic [31:0] req_exp = '0;

  // Reference model: queue occupancies and ordering from the protocol rules
  typedef struct { logic [9:0] f; logic [31:0] a; logic [31:0] b; } req_t;
  req_t        cmdq_m[$];
  logic [31:0] exp_q[$];
  logic [31:0] cfu_q[$];
  int          cq_m = 0, out_m = 0, rq_m = 0;
  bit          err_m = 0;
  int          issued_n = 0, popped_n = 0;
  bit          inj_on = 0;

  initial begin
    bit rqf, cf, rf, pf, sol, rs;
    req_t m;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_payload_outputs_0 = '0;
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      check("req_ready", req_ready, !reset && (cq_m < DEPTH));
      check("cmd_valid", cmd_valid, !reset && (cq_m > 0) && (out_m + rq_m < DEPTH));
      check("res_valid", res_valid, !reset && (rq_m > 0));
      check("rsp_ready", rsp_ready, !reset);
      check("outstanding", outstanding, out_m);
      check("error", error, err_m);
      check("idle", idle, (cq_m == 0) && (out_m == 0) && (rq_m == 0));
      rs  = reset;
      rqf = req_valid && req_ready;
      cf  = cmd_valid && cmd_ready;
      rf  = rsp_valid && rsp_ready;
      pf  = res_valid && res_ready;
      if (rs) begin
        cq_m = 0; out_m = 0; rq_m = 0; err_m = 0;
        cmdq_m.delete(); exp_q.delete(); cfu_q.delete();
      end else begin
        if (pf) begin
          popped_n++;
          if (exp_q.size() == 0) check("res_unexpected", res_data, 32'hx);
          else check("res_data_order", res_data, exp_q.pop_front());
          rq_m--;
        end
        sol = rf && (out_m > 0);
        if (rf) begin
          if (sol) rq_m++;
          else err_m = 1;
          if (!inj_on && cfu_q.size() > 0) void'(cfu_q.pop_front());
        end
        if (cf) begin
          issued_n++;
          if (cmdq_m.size() == 0) check("issue_unexpected", cmd_payload_function_id, 10'hx);
          else begin
            m = cmdq_m.pop_front();
            check("issue_payload",
                  {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1},
                  {m.f, m.a, m.b});
          end
          cq_m--;
          cfu_q.push_back(cmd_payload_inputs_0 + cmd_payload_inputs_1);
        end
        out_m = out_m + (cf ? 1 : 0) - (sol ? 1 : 0);
        if (rqf) begin
          cq_m++;
          cmdq_m.push_back('{req_function_id, req_inputs_0, req_inputs_1});
          exp_q.push_back(req_exp);
        end
      end
      @(posedge clk);
      #2;
      if (inject) begin
        rsp_valid = 1'b1;
        rsp_payload_outputs_0 = 32'hDEADBEEF;
        inj_on = 1;
        inject = 0;
      end else begin
        inj_on = 0;
        rsp_valid = !cfu_hold && (cfu_q.size() > 0) && (!cfu_rand || ($urandom % 3 != 0));
        rsp_payload_outputs_0 = (cfu_q.size() > 0) ? cfu_q[0] : 32'h0;
      end
      if (cfu_rand) cmd_ready = !cfu_stall && ($urandom % 2 == 1) && (cfu_q.size() < 2);
      else          cmd_ready = !cfu_stall && (cfu_q.size() == 0);
      res_ready = res_en && (!res_rand || ($urandom % 2 == 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e);
    int n = 0;
    req_valid = 1'b1;
    req_function_id = f;
    req_inputs_0 = a;
    req_inputs_1 = b;
    req_exp = e;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 300);
    check("req_accept", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!idle && n < lim);
    check("idle_reached", idle, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct { logic [9:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] e; } vec_t;
  vec_t tbl[6];

  initial begin
    int iss0, pop0;
    logic [31:0] ra, rb;
    tbl[0] = '{10'd0,    32'd5,          32'd7,          32'd12};
    tbl[1] = '{10'd3,    32'd0,          32'd0,          32'd0};
    tbl[2] = '{10'd1,    32'hFFFF_FFFF,  32'd1,          32'd0};
    tbl[3] = '{10'd2,    32'd100,        32'd200,        32'd300};
    tbl[4] = '{10'd1023, 32'h8000_0000,  32'h8000_0001,  32'd1};
    tbl[5] = '{10'd5,    32'd123456,     32'd654321,     32'd777777};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle", idle, 1'b1);
    check("rst_outstanding", outstanding, 3'd0);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_req_ready_after", req_ready, 1'b1);
    check("rst_rsp_ready_after", rsp_ready, 1'b1);
    @(posedge clk);
    #1;

    // Single operations against the one-cycle adder CFU
    for (int i = 0; i < 6; i++) begin
      send_req(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].e);
      @(negedge clk);
      check("vec_cmd_valid", cmd_valid, 1'b1);
      check("vec_cmd_fid", cmd_payload_function_id, tbl[i].f);
      check("vec_cmd_in0", cmd_payload_inputs_0, tbl[i].a);
      check("vec_cmd_in1", cmd_payload_inputs_1, tbl[i].b);
      @(negedge clk);
      @(negedge clk);
      check("vec_res_valid", res_valid, 1'b1);
      check("vec_res_data", res_data, tbl[i].e);
      @(posedge clk);
      #1;
      wait_idle(20);
    end

    // CFU stall: command must hold steady while cmd_ready is low
    cfu_stall = 1;
    send_req(10'd9, 32'hAAAA_0001, 32'h5555_0002, 32'hFFFF_0003);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", cmd_valid, 1'b1);
      check("stall_payload",
            {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1},
            {10'd9, 32'hAAAA_0001, 32'h5555_0002});
    end
    @(posedge clk);
    #1;
    cfu_stall = 0;
    @(negedge clk);
    check("stall_issue", cmd_valid && cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    wait_idle(20);

    // Back-pressure: consumer blocked, only DEPTH commands may issue
    res_en = 0;
    tick(1);
    iss0 = issued_n;
    pop0 = popped_n;
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      send_req(10'(i), ra, rb, ra + rb);
    end
    tick(12);
    check("bp_issued", issued_n - iss0, DEPTH);
    @(negedge clk);
    check("bp_req_ready", req_ready, 1'b0);
    check("bp_cmd_valid", cmd_valid, 1'b0);
    check("bp_outstanding", outstanding, 3'd0);
    check("bp_res_valid", res_valid, 1'b1);
    @(posedge clk);
    #1;
    res_en = 1;
    wait_idle(100);
    check("bp_popped", popped_n - pop0, 8);

    // Unsolicited response sets a sticky error
    inject = 1;
    tick(3);
    @(negedge clk);
    check("unsol_error", error, 1'b1);
    check("unsol_res_valid", res_valid, 1'b0);
    @(posedge clk);
    #1;
    tick(5);
    @(negedge clk);
    check("unsol_sticky", error, 1'b1);
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    check("unsol_cleared", error, 1'b0);
    @(posedge clk);
    #1;

    // Randomised traffic against the reference model
    cfu_rand = 1;
    res_rand = 1;
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom;
      send_req(10'($urandom_range(0, 1023)), ra, rb, ra + rb);
      if ($urandom % 4 == 0) tick($urandom_range(1, 3));
    end
    cfu_rand = 0;
    res_rand = 0;
    wait_idle(400);
    check("rand_drained", exp_q.size(), 0);

    // Reset mid-stream: one in flight, three queued
    cfu_hold = 1;
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      send_req(10'(i + 40), ra, rb, ra + rb);
    end
    tick(3);
    @(negedge clk);
    check("ms_outstanding_pre", outstanding, 3'd1);
    check("ms_cmd_valid_pre", cmd_valid, 1'b1);
    @(posedge clk);
    #1;
    pulse_reset();
    cfu_hold = 0;
    @(negedge clk);
    check("ms_outstanding", outstanding, 3'd0);
    check("ms_cmd_valid", cmd_valid, 1'b0);
    check("ms_res_valid", res_valid, 1'b0);
    check("ms_idle", idle, 1'b1);
    @(posedge clk);
    #1;
    tick(5);
    @(negedge clk);
    check("ms_no_error", error, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, expected finish before t=300000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfu_cmd_master.md
# cfu_cmd_master

Initiator for the CFU command/response interface. Accepts operations from a local request port, queues them, drives them onto a CFU's `cmd_*` channel with valid/ready handshaking, and collects each `rsp_*` result into a response queue. Used as a hardware command streamer, or as a bench-side driver, in front of any CFU that speaks the standard `cmd_valid/cmd_ready/rsp_valid/rsp_ready` protocol. Credit-based issue guarantees a result slot for every in-flight command.

## Interface
- `DEPTH`, 4: entries in each of the command and response FIFOs; power of 2, ≥2.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  request accepted this cycle if high with `req_valid`.
- `req_function_id`  in  10  function id to forward.
- `req_inputs_0`, `req_inputs_1`  in  32  operands to forward.
- `cmd_valid`  out  1  command to CFU valid.
- `cmd_ready`  in  1  CFU accepts command.
- `cmd_payload_function_id`  out  10; `cmd_payload_inputs_0`, `cmd_payload_inputs_1`  out  32  head-of-queue command.
- `rsp_valid`  in  1  CFU result valid.
- `rsp_ready`  out  1  result accepted.
- `rsp_payload_outputs_0`  in  32  CFU result.
- `res_valid`  out  1  result available to consumer.
- `res_ready`  in  1  consumer takes result.
- `res_data`  out  32  head-of-queue result.
- `outstanding`  out  $clog2(DEPTH)+1  commands issued but not yet responded.
- `idle`  out  1  command FIFO empty, `outstanding`==0, response FIFO empty.
- `error`  out  1  sticky; unsolicited response seen.

## Operation
- Command FIFO: `req_ready` = not full. A push on `req_valid && req_ready` stores {function_id, inputs_0, inputs_1}.
- Issue credit: `outstanding + res_count < DEPTH`.
- `cmd_valid` = command FIFO non-empty AND credit available. Payload = FIFO head, driven straight from storage.
- Once raised, `cmd_valid` and payload hold stable until `cmd_ready`. This holds by construction, because credit is only consumed by an issue.
- Issue on `cmd_valid && cmd_ready`: pop command FIFO, `outstanding`+1.
- `rsp_ready` is high whenever not in reset. On `rsp_valid && rsp_ready`:
  - if `outstanding`>0: push `rsp_payload_outputs_0` into response FIFO, `outstanding`−1;
  - else: drop the data, set `error`.
- Credit makes response-FIFO overflow impossible.
- Issue and response in the same cycle: `outstanding` unchanged.
- `res_valid` = response FIFO non-empty; `res_data` = head. Pop on `res_valid && res_ready`. Push and pop in the same cycle are both honoured.
- Results leave in command order. The CFU protocol is in-order, so no tags are carried.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full/empty are tracked by an occupancy count of `$clog2(DEPTH)+1` bits.
- `error` clears only on reset.

## Timing
- Reset values: `req_ready`=0 during the reset cycle and 1 afterwards; `cmd_valid`=0; `rsp_ready`=0 during reset; `res_valid`=0; `outstanding`=0; `idle`=1 after reset; `error`=0.
- Reset mid-operation: both FIFOs emptied and `outstanding` cleared in one cycle; queued and in-flight work is discarded.
  - The attached CFU must share `reset`. Otherwise a late response sets `error`.
- Request accepted at edge N → `cmd_valid` earliest in cycle N+1 (no combinational req→cmd path).
- Response captured at edge M → `res_valid` in cycle M+1.
- No combinational path from `res_ready` to `cmd_valid` within a cycle: credit updates at the edge.
- Against a one-cycle CFU that drops `cmd_ready` while its response is pending: sustained throughput is 1 command per 2 cycles, `outstanding` ≤1.
- With `res_ready`=0: at most DEPTH commands are issued, then `cmd_valid` drops until a result is popped.

## Test plan
- Reset then idle: hold `reset` 2 cycles → all outputs at reset values; `idle`=1, `outstanding`=0, `cmd_valid`=0.
- Single op vs. one-cycle add CFU: req fid=0, 5, 7 → `cmd_valid` next cycle with payload 0/5/7; `res_data`=12, `res_valid`=1; then `idle`=1.
- Back-pressure: `res_ready`=0, push 8 requests with DEPTH=4 → exactly 4 issued, `outstanding`+res_count ≤4, `req_ready`=0 after 4 more are queued. Release `res_ready` → all 8 results are returned in order.
- CFU stall: hold `cmd_ready`=0 for 5 cycles with a queued command → `cmd_valid` and payload constant throughout; issued on the first ready cycle.
- Unsolicited response: pulse `rsp_valid` with `outstanding`=0 → `error`=1 and stays 1, `res_valid` stays 0. Reset → `error`=0.
- Reset mid-stream: 3 queued, 1 in flight, assert `reset` → next cycle `outstanding`=0, FIFOs empty, `cmd_valid`=0, `res_valid`=0.
